input_control: RTL

Input-side data controller for the VEGETA engine, mirroring the output controller on the read direction. Fetches an LANE_COUNT x N operand tile from L2 BRAM over the 32-bit BRAM port, in the same lane-major layout the output path writes. Buffers the tile in an internal L1 store, then streams it into the engine with per-PE-group diagonal skew. Sits between the L2 BRAM and the `acc`-side input ports of the PE array.

---
 rtl/input_control.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/input_control.sv
// input_control: fetches a lane-major operand tile from L2 BRAM into a local
// store, then streams it into the PE groups with a one-cycle-per-group skew.
module input_control #(
  parameter int          M                = 4,
  parameter int          ALPHA            = 2,
  parameter int          DATA_WIDTH       = 16,
  parameter int          N                = 4,
  parameter logic [31:0] L2_INPUT_ADDRESS = 32'h4000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          input_start,
  output logic [31:0]                   input_address,
  output logic                          input_L2_enable,
  output logic [3:0]                    input_L2_wenable,
  input  logic [31:0]                   input_data,
  input  logic                          engine_stall,
  output logic [ALPHA*DATA_WIDTH-1:0]   engine_data [0:M/ALPHA-1],
  output logic [M/ALPHA-1:0]            engine_valid,
  output logic                          busy,
  output logic                          stream_done
);

  localparam int MS    = M / ALPHA;
  localparam int LC    = MS * ALPHA;
  localparam int TOT   = LC * N;
  localparam int SC    = N + MS - 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int TW    = (SC > 1) ? $clog2(SC) : 1;
  localparam int DW    = DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L2_LOAD,
    S_LOAD_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_tag;
  logic            r_tag_v;
  logic [TW-1:0]   r_t;
  logic [DW-1:0]   r_store [0:TOT-1];

  logic [ALPHA*DW-1:0] w_data [0:MS-1];
  logic [MS-1:0]       w_valid;
  logic                w_unused;

  assign input_L2_wenable = 4'b0000;
  assign w_unused         = ^input_data;

  // Group p sees column t-p of its lanes while 0 <= t-p < N.
  always_comb begin
    for (int p = 0; p < MS; p++) begin
      w_data[p]  = '0;
      w_valid[p] = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (r_t == TW'(p + k)) begin
          w_valid[p] = 1'b1;
          for (int a = 0; a < ALPHA; a++) begin
            w_data[p][a*DW +: DW] = r_store[(p*ALPHA + a)*N + k];
          end
        end
      end
    end
  end

  // Tag lags the address by one cycle to match the BRAM read latency.
  always_ff @(posedge clk) begin
    if (r_tag_v) begin
      r_store[r_tag] <= input_data[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_tag           <= '0;
      r_tag_v         <= 1'b0;
      r_t             <= '0;
      input_address   <= '0;
      input_L2_enable <= 1'b0;
      engine_valid    <= '0;
      busy            <= 1'b0;
      stream_done     <= 1'b0;
      for (int p = 0; p < MS; p++) begin
        engine_data[p] <= '0;
      end
    end else begin
      stream_done <= 1'b0;
      r_tag_v     <= (r_state == S_L2_LOAD);
      r_tag       <= r_idx;
      case (r_state)
        S_IDLE: begin
          if (input_start) begin
            r_state         <= S_L2_LOAD;
            r_idx           <= '0;
            input_address   <= L2_INPUT_ADDRESS;
            input_L2_enable <= 1'b1;
            busy            <= 1'b1;
          end
        end
        S_L2_LOAD: begin
          if (r_idx == IW'(TOT - 1)) begin
            input_L2_enable <= 1'b0;
            r_state         <= S_LOAD_WAIT;
          end else begin
            r_idx         <= r_idx + IW'(1);
            input_address <= input_address + 32'(BYTES);
          end
        end
        S_LOAD_WAIT: begin
          r_t     <= '0;
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (!engine_stall) begin
            engine_valid <= w_valid;
            for (int p = 0; p < MS; p++) begin
              engine_data[p] <= w_data[p];
            end
            if (r_t == TW'(SC - 1)) begin
              r_state <= S_DONE;
            end else begin
              r_t <= r_t + TW'(1);
            end
          end
        end
        S_DONE: begin
          stream_done  <= 1'b1;
          busy         <= 1'b0;
          engine_valid <= '0;
          for (int p = 0; p < MS; p++) begin
            engine_data[p] <= '0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
